// File: rtl/p4_router_ipv4_chksum_extern.sv
// p4_router_ipv4_chksum_extern
//
// Fixed-latency responder for the UserIPv4ChkVerify and UserIPv4ChkUpdate
// user externs of the Vitis Networking P4 IP. Each lane (verify = bit 0,
// update = bit 1) carries its own valid bit through the pipe. A response
// appears exactly LATENCY cycles after its request, in order. There is no
// backpressure. Saturating counters tally the emitted responses.
//
// Ports
//   clk               core clock (AXIS domain of the P4 IP)
//   rst               synchronous active-high reset
//   extern_out        [159:0] IPv4 header, [191:176] hdr_chk,
//                     [175:168] old_ttl, [167:160] new_ttl
//   extern_out_valid  [0] verify request, [1] update request
//   extern_in         [0] verify result, [16:1] updated checksum
//   extern_in_valid   [0] verify response, [1] update response
//   cnt_clear         synchronous clear of all counters
//   verify_cnt        verify responses emitted
//   verify_fail_cnt   verify responses with result 0
//   update_cnt        update responses emitted
module p4_router_ipv4_chksum_extern #(
  parameter int LATENCY    = 4,
  parameter int STRICT_HDR = 1,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [191:0]         extern_out,
  input  logic [1:0]           extern_out_valid,
  output logic [16:0]          extern_in,
  output logic [1:0]           extern_in_valid,
  input  logic                 cnt_clear,
  output logic [CNT_WIDTH-1:0] verify_cnt,
  output logic [CNT_WIDTH-1:0] verify_fail_cnt,
  output logic [CNT_WIDTH-1:0] update_cnt
);

  // Four register stages are fixed (input, partial sums, fold, output).
  // Any extra latency is absorbed by a delay line placed before the output
  // register.
  localparam int DLY = LATENCY - 4;

  if (LATENCY < 4 || LATENCY > 32) begin : g_bad_latency
    $error("p4_router_ipv4_chksum_extern: LATENCY must be within 4..32");
  end

  // Stage 1: input register
  logic [159:0] s1_hdr;
  logic [15:0]  s1_chk;
  logic [7:0]   s1_old_ttl;
  logic [7:0]   s1_new_ttl;
  logic [1:0]   s1_v;

  always_ff @(posedge clk) begin
    if (rst) s1_v <= 2'b00;
    else     s1_v <= extern_out_valid;
  end

  always_ff @(posedge clk) begin
    s1_hdr     <= extern_out[159:0];
    s1_chk     <= extern_out[191:176];
    s1_old_ttl <= extern_out[175:168];
    s1_new_ttl <= extern_out[167:160];
  end

  // Stage 2: pairwise partial sums
  logic [16:0] s2_psum [5];
  logic        s2_hdr_ok;
  logic [16:0] s2_upd_sum;
  logic [7:0]  s2_new_ttl;
  logic [1:0]  s2_v;

  always_ff @(posedge clk) begin
    if (rst) s2_v <= 2'b00;
    else     s2_v <= s1_v;
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 5; i++) begin
      s2_psum[i] <= {1'b0, s1_hdr[159-32*i -: 16]} + {1'b0, s1_hdr[143-32*i -: 16]};
    end
    s2_hdr_ok  <= (s1_hdr[159:156] == 4'd4) && (s1_hdr[155:152] == 4'd5);
    // Removing the old TTL term: ~HC + ~m, with the carry folded in stage 3.
    s2_upd_sum <= {1'b0, ~s1_chk} + {1'b0, ~{s1_old_ttl, 8'h00}};
    s2_new_ttl <= s1_new_ttl;
  end

  // Stage 3: final sum and end-around fold
  logic [19:0] s3_total;
  logic [16:0] s3_fold1;
  logic [15:0] s3_fold2;
  logic [15:0] s3_u1;
  logic [16:0] s3_u2;
  logic [15:0] s3_u3;
  logic        s3_ver_next;

  always_comb begin
    s3_total = {3'b000, s2_psum[0]} + {3'b000, s2_psum[1]} + {3'b000, s2_psum[2]}
             + {3'b000, s2_psum[3]} + {3'b000, s2_psum[4]};
    // Two folds are enough: the first one leaves at most a single carry.
    s3_fold1 = {1'b0, s3_total[15:0]} + {13'b0, s3_total[19:16]};
    s3_fold2 = s3_fold1[15:0] + {15'b0, s3_fold1[16]};
    s3_ver_next = (s3_fold2 == 16'hFFFF) && ((STRICT_HDR == 0) || s2_hdr_ok);

    s3_u1 = s2_upd_sum[15:0] + {15'b0, s2_upd_sum[16]};
    s3_u2 = {1'b0, s3_u1} + {1'b0, s2_new_ttl, 8'h00};
    s3_u3 = s3_u2[15:0] + {15'b0, s3_u2[16]};
  end

  logic [16:0] s3_data;
  logic [1:0]  s3_v;

  always_ff @(posedge clk) begin
    if (rst) s3_v <= 2'b00;
    else     s3_v <= s2_v;
  end

  always_ff @(posedge clk) begin
    s3_data <= {~s3_u3, s3_ver_next};
  end

  // Latency alignment line
  logic [16:0] d_data;
  logic [1:0]  d_v;

  if (DLY > 0) begin : g_delay
    logic [16:0] dl_data [DLY];
    logic [1:0]  dl_v    [DLY];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < DLY; i++) dl_v[i] <= 2'b00;
      end else begin
        dl_v[0] <= s3_v;
        for (int i = 1; i < DLY; i++) dl_v[i] <= dl_v[i-1];
      end
    end

    always_ff @(posedge clk) begin
      dl_data[0] <= s3_data;
      for (int i = 1; i < DLY; i++) dl_data[i] <= dl_data[i-1];
    end

    assign d_data = dl_data[DLY-1];
    assign d_v    = dl_v[DLY-1];
  end else begin : g_no_delay
    assign d_data = s3_data;
    assign d_v    = s3_v;
  end

  // Output register. Idle lanes are driven to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      extern_in       <= 17'h0;
      extern_in_valid <= 2'b00;
    end else begin
      extern_in       <= {(d_v[1] ? d_data[16:1] : 16'h0000), (d_v[0] & d_data[0])};
      extern_in_valid <= d_v;
    end
  end

  // The counters advance on the same edge that launches the response, so
  // a clear asserted on that edge wins and the response goes uncounted.
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  always_ff @(posedge clk) begin
    if (rst || cnt_clear) begin
      verify_cnt      <= '0;
      verify_fail_cnt <= '0;
      update_cnt      <= '0;
    end else begin
      if (d_v[0] && verify_cnt != CNT_MAX)
        verify_cnt <= verify_cnt + CNT_ONE;
      if (d_v[0] && !d_data[0] && verify_fail_cnt != CNT_MAX)
        verify_fail_cnt <= verify_fail_cnt + CNT_ONE;
      if (d_v[1] && update_cnt != CNT_MAX)
        update_cnt <= update_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_p4_router_ipv4_chksum_extern.sv
module tb_p4_router_ipv4_chksum_extern;

  localparam logic [159:0] HDR_GOOD  = 160'h4500_0073_0000_4000_4011_B861_C0A8_0001_C0A8_00C7;
  localparam logic [159:0] HDR_BADCK = 160'h4500_0073_0000_4000_4011_B862_C0A8_0001_C0A8_00C7;
  localparam logic [159:0] HDR_V6    = 160'h6500_0073_0000_4000_4011_9861_C0A8_0001_C0A8_00C7;

  logic         clk = 1'b0;
  logic         rst;
  logic [191:0] extern_out;
  logic [1:0]   extern_out_valid;
  logic         cnt_clear;

  // u_a: LATENCY 4, strict header, 4-bit counters
  logic [16:0] a_in;
  logic [1:0]  a_valid;
  logic [3:0]  a_vcnt, a_fcnt, a_ucnt;
  // u_b: LATENCY 17, relaxed header, 32-bit counters
  logic [16:0] b_in;
  logic [1:0]  b_valid;
  logic [31:0] b_vcnt, b_fcnt, b_ucnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  p4_router_ipv4_chksum_extern #(.LATENCY(4), .STRICT_HDR(1), .CNT_WIDTH(4)) u_a (
    .clk(clk), .rst(rst), .extern_out(extern_out), .extern_out_valid(extern_out_valid),
    .extern_in(a_in), .extern_in_valid(a_valid), .cnt_clear(cnt_clear),
    .verify_cnt(a_vcnt), .verify_fail_cnt(a_fcnt), .update_cnt(a_ucnt)
  );

  p4_router_ipv4_chksum_extern #(.LATENCY(17), .STRICT_HDR(0), .CNT_WIDTH(32)) u_b (
    .clk(clk), .rst(rst), .extern_out(extern_out), .extern_out_valid(extern_out_valid),
    .extern_in(b_in), .extern_in_valid(b_valid), .cnt_clear(cnt_clear),
    .verify_cnt(b_vcnt), .verify_fail_cnt(b_fcnt), .update_cnt(b_ucnt)
  );

  function automatic logic [15:0] oc_add(input logic [15:0] x, input logic [15:0] y);
    logic [16:0] s;
    s = {1'b0, x} + {1'b0, y};
    return s[15:0] + {15'b0, s[16]};
  endfunction

  function automatic logic [15:0] hdr_sum(input logic [159:0] h);
    logic [15:0] acc;
    acc = 16'h0000;
    for (int k = 0; k < 10; k++) acc = oc_add(acc, h[159-16*k -: 16]);
    return acc;
  endfunction

  function automatic logic [15:0] upd_model(input logic [15:0] hc, input logic [7:0] o,
                                             input logic [7:0] n);
    return ~oc_add(oc_add(~hc, ~{o, 8'h00}), {n, 8'h00});
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one request for one cycle, then return the inputs to idle.
  task automatic send(input logic [191:0] d, input logic [1:0] v);
    extern_out       = d;
    extern_out_valid = v;
    step();
    extern_out       = '0;
    extern_out_valid = 2'b00;
  endtask

  task automatic idle(input int n);
    extern_out       = '0;
    extern_out_valid = 2'b00;
    repeat (n) step();
  endtask

  logic [191:0] r_out [50];
  logic [16:0]  r_exp [50];
  int           n_fail;
  logic [31:0]  rnd;
  logic [159:0] rh;
  logic [15:0]  rchk;
  logic [7:0]   rot, rnt;
  logic         seen_a, seen_b;

  initial begin
    rst = 1'b1;
    cnt_clear = 1'b0;
    extern_out = '0;
    extern_out_valid = 2'b00;

    // Reset state
    repeat (3) step();
    chk("rst_a_in", 64'(a_in), 64'h0);
    chk("rst_a_valid", 64'(a_valid), 64'h0);
    chk("rst_a_cnts", 64'({a_vcnt, a_fcnt, a_ucnt}), 64'h0);
    chk("rst_b_valid", 64'(b_valid), 64'h0);
    rst = 1'b0;
    step();

    // Good header: u_a answers after exactly 4 cycles, u_b after 17
    send({32'h0, HDR_GOOD}, 2'b01);
    repeat (2) step();
    chk("good_a_early", 64'(a_valid), 64'h0);
    step();
    chk("good_a_valid", 64'(a_valid), 64'h1);
    chk("good_a_in", 64'(a_in), 64'h1);
    chk("good_a_vcnt", 64'(a_vcnt), 64'd1);
    chk("good_a_fcnt", 64'(a_fcnt), 64'd0);
    repeat (12) step();
    chk("good_b_early", 64'(b_valid), 64'h0);
    step();
    chk("good_b_resp", 64'({b_valid, b_in}), 64'({2'b01, 17'h1}));
    idle(2);

    // Bad checksum
    send({32'h0, HDR_BADCK}, 2'b01);
    repeat (3) step();
    chk("badck_a_resp", 64'({a_valid, a_in}), 64'({2'b01, 17'h0}));
    chk("badck_a_fcnt", 64'(a_fcnt), 64'd1);
    chk("badck_a_vcnt", 64'(a_vcnt), 64'd2);
    idle(16);

    // Version 6 with valid checksum: strict rejects, relaxed accepts
    send({32'h0, HDR_V6}, 2'b01);
    repeat (3) step();
    chk("v6_a_strict", 64'({a_valid, a_in}), 64'({2'b01, 17'h0}));
    chk("v6_a_fcnt", 64'(a_fcnt), 64'd2);
    repeat (13) step();
    chk("v6_b_relaxed", 64'({b_valid, b_in}), 64'({2'b01, 17'h1}));
    idle(2);

    // TTL decrement update; the header field is a good header to show
    // that an idle verify lane stays zero
    send({16'hB861, 8'h40, 8'h3F, HDR_GOOD}, 2'b10);
    repeat (3) step();
    chk("upd1_a_resp", 64'({a_valid, a_in}), 64'({2'b10, 16'hB961, 1'b0}));
    chk("upd1_a_ucnt", 64'(a_ucnt), 64'd1);
    idle(16);

    send({16'hFFFF, 8'h01, 8'h00, 160'h0}, 2'b10);
    repeat (3) step();
    chk("upd2_a_resp", 64'({a_valid, a_in}), 64'({2'b10, 16'h0100, 1'b0}));
    idle(16);

    // Both lanes on the same cycle
    send({16'hB861, 8'h40, 8'h3F, HDR_GOOD}, 2'b11);
    repeat (3) step();
    chk("both_a_resp", 64'({a_valid, a_in}), 64'({2'b11, 16'hB961, 1'b1}));
    chk("both_a_cnts", 64'({a_vcnt, a_fcnt, a_ucnt}), 64'({4'd4, 4'd2, 4'd3}));
    idle(16);

    // Saturation of 4-bit counters with 20 failing verifies
    rst = 1'b1;
    step();
    rst = 1'b0;
    extern_out = {32'h0, HDR_BADCK};
    extern_out_valid = 2'b01;
    repeat (20) step();
    idle(20);
    chk("sat_a_fcnt", 64'(a_fcnt), 64'hF);
    chk("sat_a_vcnt", 64'(a_vcnt), 64'hF);
    chk("sat_b_fcnt", 64'(b_fcnt), 64'd20);

    cnt_clear = 1'b1;
    step();
    cnt_clear = 1'b0;
    chk("clr_a_fcnt", 64'(a_fcnt), 64'h0);
    chk("clr_b_vcnt", 64'(b_vcnt), 64'h0);

    // Clear on the edge that emits a response: response goes out uncounted
    send({32'h0, HDR_GOOD}, 2'b01);
    repeat (2) step();
    cnt_clear = 1'b1;
    step();
    cnt_clear = 1'b0;
    chk("clrprio_a_valid", 64'(a_valid), 64'h1);
    chk("clrprio_a_vcnt", 64'(a_vcnt), 64'h0);
    step();
    chk("clrprio_a_vcnt_hold", 64'(a_vcnt), 64'h0);
    idle(16);

    // LATENCY=17 stream: both lanes every cycle for 50 cycles
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_fail = 0;
    for (int i = 0; i < 50; i++) begin
      for (int w = 0; w < 5; w++) begin
        rnd = $urandom;
        rh[159-32*w -: 32] = rnd;
      end
      if (i % 2 == 1) begin
        rh[79:64] = 16'h0000;
        rh[79:64] = ~hdr_sum(rh);
      end
      rnd  = $urandom;
      rchk = rnd[15:0];
      rot  = rnd[23:16];
      rnt  = rnd[31:24];
      r_out[i] = {rchk, rot, rnt, rh};
      r_exp[i] = {upd_model(rchk, rot, rnt), (hdr_sum(rh) == 16'hFFFF)};
      if (hdr_sum(rh) != 16'hFFFF) n_fail++;
    end
    for (int s = 0; s < 70; s++) begin
      if (s < 50) begin
        extern_out       = r_out[s];
        extern_out_valid = 2'b11;
      end else begin
        extern_out       = '0;
        extern_out_valid = 2'b00;
      end
      step();
      if (s >= 16 && s - 16 < 50)
        chk($sformatf("stream_b_%0d", s - 16), 64'({b_valid, b_in}), 64'({2'b11, r_exp[s-16]}));
      else
        chk($sformatf("stream_b_idle_%0d", s), 64'({b_valid, b_in}), 64'h0);
    end
    chk("stream_b_vcnt", 64'(b_vcnt), 64'd50);
    chk("stream_b_ucnt", 64'(b_ucnt), 64'd50);
    chk("stream_b_fcnt", 64'(b_fcnt), 64'(n_fail));

    // Reset with three requests in flight
    extern_out_valid = 2'b11;
    extern_out = {16'hB861, 8'h40, 8'h3F, HDR_GOOD};
    repeat (3) step();
    extern_out_valid = 2'b00;
    rst = 1'b1;
    step();
    rst = 1'b0;
    seen_a = 1'b0;
    seen_b = 1'b0;
    for (int s = 0; s < 20; s++) begin
      step();
      if (a_valid != 2'b00) seen_a = 1'b1;
      if (b_valid != 2'b00) seen_b = 1'b1;
    end
    chk("midrst_a_none", 64'(seen_a), 64'h0);
    chk("midrst_b_none", 64'(seen_b), 64'h0);
    chk("midrst_a_cnts", 64'({a_vcnt, a_fcnt, a_ucnt}), 64'h0);
    chk("midrst_b_cnts", 64'({b_vcnt, b_fcnt, b_ucnt}), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/p4_router_ipv4_chksum_extern.md
Name: p4_router_ipv4_chksum_extern

Overview:
- Pipelined responder for the two Vitis Networking P4 user externs, UserIPv4ChkVerify and UserIPv4ChkUpdate.
- Sits beside the vitis_net_p4 instance in the P4 router. Consumes the IP's user_extern_out and user_extern_out_valid buses; returns user_extern_in and user_extern_in_valid after a fixed, parametrised latency.
- Adds strict-header checking, a configurable latency alignment line, and saturating statistics counters.

Parameters:
- LATENCY, 4, cycles from extern_out_valid to extern_in_valid; legal range 4..32. Must equal the IP's configured extern latency.
- STRICT_HDR, 1, if 1 the verify result also requires version==4 and hdr_len==5.
- CNT_WIDTH, 32, width of the statistics counters.

Ports:
- clk  in  1  core clock (AXIS clock domain of the P4 IP)
- rst  in  1  synchronous active-high reset
- extern_out  in  192  [159:0] IPv4 header (version at [159:156], dst at [31:0]); [191:176] hdr_chk, [175:168] old_ttl, [167:160] new_ttl
- extern_out_valid  in  2  [0] verify request, [1] update request
- extern_in  out  17  [0] verify result (1 = header good); [16:1] updated checksum
- extern_in_valid  out  2  [0] verify response, [1] update response
- cnt_clear  in  1  synchronous clear of all counters
- verify_cnt  out  CNT_WIDTH  verify requests processed
- verify_fail_cnt  out  CNT_WIDTH  verify responses with result 0
- update_cnt  out  CNT_WIDTH  update requests processed

Behaviour:
- Reset values: all outputs 0; pipeline valid bits cleared.
- Interface has no backpressure: a request is accepted every cycle its valid bit is 1.
  - Each accepted request produces exactly one response, exactly LATENCY cycles later, in order.
- Verify and update lanes are independent. They may be valid on the same cycle or on different cycles; each lane carries its own valid through the pipe.
- When a lane's response valid is 0, its extern_in field is 0.
- Verify arithmetic:
  - One's-complement sum of the ten 16-bit header words, with end-around carry folded.
  - Checksum good when the folded sum == 16'hFFFF.
  - Result = checksum good AND (STRICT_HDR==0 OR (version==4 AND hdr_len==5)).
- Update arithmetic (RFC 1624): new = ~(~hdr_chk +' ~{old_ttl,8'h00} +' {new_ttl,8'h00}), where +' is a 16-bit end-around-carry add.
  - The result 16'h0000 is never produced for a nonzero header; no special-casing is applied.
- Pipeline structure:
  - Stage 1: register inputs.
  - Stage 2: pairwise 17-bit partial sums.
  - Stage 3: final sum and fold.
  - Output register: result.
  - A delay shift register of LATENCY-4 stages (data and valid) sits before the output register.
  - When LATENCY==4 the shift register is absent.
- Counters:
  - Each counter increments on response emission (output stage), not on request.
  - Counters saturate at all-ones; no wrap.
  - cnt_clear has priority over an increment in the same cycle: the counter becomes 0 and that cycle's event is not counted.
- Reset mid-operation: all in-flight requests are discarded, no responses are emitted for them, and counters return to 0.
- Illegal LATENCY (outside 4..32) raises an elaboration-time $error.

Test Plan:
- Header 4500_0073_0000_4000_4011_B861_C0A8_0001_C0A8_00C7, verify valid for 1 cycle, LATENCY=4 -> extern_in_valid=2'b01 exactly 4 cycles later, extern_in[0]=1, verify_cnt=1, verify_fail_cnt=0.
- Same header with checksum B862 -> extern_in[0]=0 and verify_fail_cnt=1. Same header with version 6 and correct checksum, STRICT_HDR=1 -> result 0; STRICT_HDR=0 -> result 1.
- Update hdr_chk=B861, old_ttl=40, new_ttl=3F -> extern_in[16:1]=B961, extern_in_valid=2'b10. With old_ttl=01, new_ttl=00, hdr_chk=FFFF -> 0100.
- LATENCY=17, both lanes valid on back-to-back cycles for 50 cycles with random headers -> 50 responses per lane, each exactly 17 cycles after its request, in order, all matching the reference model.
- CNT_WIDTH=4, 20 failing verifies -> verify_fail_cnt holds at 15. Assert cnt_clear on the cycle a response emits -> counter reads 0 the next cycle.
- Assert rst for 1 cycle while 3 requests are in flight -> no extern_in_valid during the following LATENCY cycles, and all counters read 0.
